// File: rtl/audio_buffer_player_pkg.sv
// Shared types and constants for the audio buffer player.
// Buffer geometry matches the sector buffer filled by the FAT32 reader.
package audio_buffer_player_pkg;
    localparam int BUFFER_ADDR_BITS_DEFAULT = 9;  // one 512-byte sector
    localparam int FRAME_BYTES_MONO         = 2;
    localparam int FRAME_BYTES_STEREO       = 4;
    localparam int EOS_BIT                  = 8;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_PLAY,
        ST_FETCH,
        ST_EMIT
    } player_state_t;
endpackage

// File: rtl/audio_buffer_player_tick.sv
// Fractional rate divider: one-cycle tick at SAMPLE_HZ on average from a CLK_HZ clock.
module sample_tick_gen #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 44100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    logic [31:0] acc;
    logic [32:0] acc_sum;

    // One spare bit so the compare cannot be fooled by overflow.
    assign acc_sum = {1'b0, acc} + 33'(SAMPLE_HZ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (acc_sum >= 33'(CLK_HZ)) begin
            acc  <= 32'(acc_sum - 33'(CLK_HZ));
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum[31:0];
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/audio_buffer_player.sv
// Drains the audio buffer at the sample rate, assembling 16-bit LE PCM frames
// (mono or stereo) for the DAC stage and handing the buffer back when done.
module audio_buffer_player
    import audio_buffer_player_pkg::*;
#(
    parameter int CLK_HZ           = 50_000_000,
    parameter int SAMPLE_HZ        = 44100,
    parameter int BUFFER_ADDR_BITS = BUFFER_ADDR_BITS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [BUFFER_ADDR_BITS-1:0] buffer_addr_o,
    input  logic [8:0]                  buffer_data_i,
    input  logic                        buffer_filled_i,
    output logic                        buffer_empty_o,
    input  logic [7:0]                  wav_info_audio_channels,
    output logic [15:0]                 left_o,
    output logic [15:0]                 right_o,
    output logic                        sample_valid_o,
    output logic                        underrun_o,
    output logic                        end_of_stream_o
);
    localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_LAST = '1;
    localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_ONE  = 1;

    player_state_t state, state_next;
    logic          tick;
    logic          stereo;
    logic [1:0]    issue_cnt, last_idx, cap_idx;
    logic          cap_en, eos_flag, wrapped;
    logic [7:0]    b0, b1, b2, cap_byte;
    logic          cap_eos;

    sample_tick_gen #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign last_idx       = stereo ? 2'(FRAME_BYTES_STEREO - 1) : 2'(FRAME_BYTES_MONO - 1);
    // Once the marker is seen, the rest of the frame plays as silence.
    assign cap_byte       = eos_flag ? 8'h00 : buffer_data_i[7:0];
    assign cap_eos        = eos_flag | buffer_data_i[EOS_BIT];
    assign buffer_empty_o = (state == ST_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_WAIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:  if (buffer_filled_i) state_next = ST_PLAY;
            ST_PLAY:  if (tick) state_next = ST_FETCH;
            ST_FETCH: if (issue_cnt == last_idx) state_next = ST_EMIT;
            ST_EMIT:  state_next = (cap_eos || wrapped) ? ST_WAIT : ST_PLAY;
            default:  state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer_addr_o   <= '0;
            stereo          <= 1'b0;
            issue_cnt       <= '0;
            cap_en          <= 1'b0;
            cap_idx         <= '0;
            eos_flag        <= 1'b0;
            wrapped         <= 1'b0;
            b0              <= '0;
            b1              <= '0;
            b2              <= '0;
            left_o          <= '0;
            right_o         <= '0;
            sample_valid_o  <= 1'b0;
            underrun_o      <= 1'b0;
            end_of_stream_o <= 1'b0;
        end else begin
            sample_valid_o  <= 1'b0;
            underrun_o      <= 1'b0;
            end_of_stream_o <= 1'b0;
            // RAM data lags the address by one cycle.
            cap_en          <= (state == ST_FETCH);
            cap_idx         <= issue_cnt;
            if (cap_en && state != ST_EMIT) begin
                eos_flag <= cap_eos;
                case (cap_idx)
                    2'd0:    b0 <= cap_byte;
                    2'd1:    b1 <= cap_byte;
                    default: b2 <= cap_byte;
                endcase
            end
            case (state)
                ST_WAIT: begin
                    buffer_addr_o <= '0;
                    issue_cnt     <= '0;
                    eos_flag      <= 1'b0;
                    wrapped       <= 1'b0;
                    if (buffer_filled_i) stereo <= (wav_info_audio_channels == 8'd2);
                    if (tick) begin
                        left_o         <= '0;
                        right_o        <= '0;
                        sample_valid_o <= 1'b1;
                        underrun_o     <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    issue_cnt <= '0;
                    eos_flag  <= 1'b0;
                end
                ST_FETCH: begin
                    buffer_addr_o <= buffer_addr_o + ADDR_ONE;
                    issue_cnt     <= issue_cnt + 2'd1;
                    if (buffer_addr_o == ADDR_LAST) wrapped <= 1'b1;
                end
                ST_EMIT: begin
                    sample_valid_o <= 1'b1;
                    if (stereo) begin
                        left_o  <= {b1, b0};
                        right_o <= {cap_byte, b2};
                    end else begin
                        left_o  <= {cap_byte, b0};
                        right_o <= {cap_byte, b0};
                    end
                    if (cap_eos) begin
                        end_of_stream_o <= 1'b1;
                        buffer_addr_o   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_buffer_player.sv
// Bench for audio_buffer_player: constant-vector table, directed corner sequences
// and randomized buffers checked against a frame-level reference model.
module tb_audio_buffer_player;
    localparam int CLK_HZ = 1_000_000;
    localparam int SAMPLE_HZ = 44100;
    localparam int AB = 4;
    localparam int DEPTH = 1 << AB;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [AB-1:0] buffer_addr_o;
    logic [8:0]    buffer_data_i = '0;
    logic          buffer_filled_i = 0;
    logic          buffer_empty_o;
    logic [7:0]    wav_ch = 8'd1;
    logic [15:0]   left_o, right_o;
    logic          sample_valid_o, underrun_o, end_of_stream_o;

    audio_buffer_player #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .BUFFER_ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .buffer_addr_o(buffer_addr_o), .buffer_data_i(buffer_data_i),
        .buffer_filled_i(buffer_filled_i), .buffer_empty_o(buffer_empty_o),
        .wav_info_audio_channels(wav_ch),
        .left_o(left_o), .right_o(right_o),
        .sample_valid_o(sample_valid_o), .underrun_o(underrun_o), .end_of_stream_o(end_of_stream_o)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [DEPTH];
    always @(posedge clk) buffer_data_i <= mem[buffer_addr_o];

    typedef struct { int e; logic [15:0] l, r; bit v, u, eos, emp; } ev_t;
    typedef struct { logic [15:0] l, r; bit eos; } frame_t;
    typedef struct { int ch; logic [8:0] b0, b1, b2, b3; logic [15:0] el, er; bit eeos; } vec_t;

    ev_t    ev[$];
    frame_t exp_q[$];
    int     ecnt = 0;
    int     n_vec = 0;
    int     n_err = 0;

    // Edge index since reset release; observed strobes are logged with it.
    always @(posedge clk) begin
        if (!rst_n) ecnt = 0;
        else ecnt = ecnt + 1;
        #1;
        if (sample_valid_o || underrun_o || end_of_stream_o)
            ev.push_back('{e: ecnt, l: left_o, r: right_o, v: sample_valid_o,
                           u: underrun_o, eos: end_of_stream_o, emp: buffer_empty_o});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // A sample tick is registered at edge k when k*S/C crosses an integer.
    function automatic bit is_tick(input int k);
        if (k < 1) return 0;
        return ((longint'(k) * SAMPLE_HZ) / CLK_HZ) != ((longint'(k - 1) * SAMPLE_HZ) / CLK_HZ);
    endfunction

    task automatic build_model(input int ch);
        int n;
        bit eos;
        logic [7:0] b [4];
        n = (ch == 2) ? 4 : 2;
        eos = 0;
        exp_q.delete();
        for (int base = 0; base < DEPTH && !eos; base += n) begin
            for (int j = 0; j < 4; j++) b[j] = 8'h00;
            for (int j = 0; j < n; j++) begin
                if (eos) b[j] = 8'h00;
                else begin
                    b[j] = mem[base + j][7:0];
                    eos  = mem[base + j][8];
                end
            end
            if (n == 4) exp_q.push_back('{l: {b[1], b[0]}, r: {b[3], b[2]}, eos: eos});
            else        exp_q.push_back('{l: {b[1], b[0]}, r: {b[1], b[0]}, eos: eos});
        end
    endtask

    task automatic check_play(input int ch, input string nm);
        int n, fi;
        n = (ch == 2) ? 4 : 2;
        fi = 0;
        build_model(ch);
        foreach (ev[i]) begin
            if (ev[i].u) begin
                chk({nm, "_ur_out"}, {ev[i].l, ev[i].r}, 32'h0);
                chk({nm, "_ur_tick"}, 32'(is_tick(ev[i].e - 1)), 32'h1);
            end else if (ev[i].v) begin
                if (fi < exp_q.size()) begin
                    chk({nm, "_left"}, 32'(ev[i].l), 32'(exp_q[fi].l));
                    chk({nm, "_right"}, 32'(ev[i].r), 32'(exp_q[fi].r));
                    chk({nm, "_eos"}, 32'(ev[i].eos), 32'(exp_q[fi].eos));
                    chk({nm, "_empty"}, 32'(ev[i].emp), 32'(fi == exp_q.size() - 1));
                    chk({nm, "_latency"}, 32'(is_tick(ev[i].e - n - 2)), 32'h1);
                end
                fi++;
            end else begin
                chk({nm, "_stray_eos"}, 32'(ev[i].eos), 32'h0);
            end
        end
        chk({nm, "_frames"}, fi, exp_q.size());
    endtask

    task automatic play(input int ch, input string nm);
        int n;
        n = 0;
        ev.delete();
        wav_ch = 8'(ch);
        @(negedge clk) buffer_filled_i = 1;
        @(negedge clk) buffer_filled_i = 0;
        wav_ch = 8'hEE;
        chk({nm, "_claim"}, 32'(buffer_empty_o), 32'h0);
        while (!buffer_empty_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_bound"}, 32'(n < 2000), 32'h1);
        repeat (2) @(negedge clk);
        chk({nm, "_addr_home"}, 32'(buffer_addr_o), 32'h0);
        check_play(ch, nm);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk) rst_n = 0;
        repeat (2) @(negedge clk);
        chk({nm, "_empty"}, 32'(buffer_empty_o), 32'h1);
        chk({nm, "_out"}, {left_o, right_o}, 32'h0);
        chk({nm, "_strobes"}, {29'h0, sample_valid_o, underrun_o, end_of_stream_o}, 32'h0);
        chk({nm, "_addr"}, 32'(buffer_addr_o), 32'h0);
        rst_n = 1;
    endtask

    task automatic fill_random(input bit with_eos);
        int pos;
        pos = with_eos ? $urandom_range(DEPTH - 1, 0) : -1;
        for (int i = 0; i < DEPTH; i++) mem[i] = {1'b0, 8'($urandom)};
        if (pos >= 0) mem[pos][8] = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        int ur, bad, fi, w, ch, idx;
        vecs[0] = '{ch: 1, b0: 9'h034, b1: 9'h012, b2: 9'h0CD, b3: 9'h0AB, el: 16'h1234, er: 16'h1234, eeos: 0};
        vecs[1] = '{ch: 1, b0: 9'h0CD, b1: 9'h0AB, b2: 9'h000, b3: 9'h000, el: 16'hABCD, er: 16'hABCD, eeos: 0};
        vecs[2] = '{ch: 2, b0: 9'h001, b1: 9'h000, b2: 9'h0FF, b3: 9'h0FF, el: 16'h0001, er: 16'hFFFF, eeos: 0};
        vecs[3] = '{ch: 2, b0: 9'h078, b1: 9'h156, b2: 9'h011, b3: 9'h022, el: 16'h5678, er: 16'h0000, eeos: 1};
        vecs[4] = '{ch: 3, b0: 9'h000, b1: 9'h080, b2: 9'h011, b3: 9'h022, el: 16'h8000, er: 16'h8000, eeos: 0};
        vecs[5] = '{ch: 0, b0: 9'h0FF, b1: 9'h07F, b2: 9'h011, b3: 9'h022, el: 16'h7FFF, er: 16'h7FFF, eeos: 0};
        vecs[6] = '{ch: 1, b0: 9'h1AA, b1: 9'h055, b2: 9'h011, b3: 9'h022, el: 16'h00AA, er: 16'h00AA, eeos: 1};
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        do_reset("reset");

        foreach (vecs[i]) begin
            for (int j = 0; j < DEPTH; j++) mem[j] = '0;
            mem[0] = vecs[i].b0; mem[1] = vecs[i].b1; mem[2] = vecs[i].b2; mem[3] = vecs[i].b3;
            mem[4] = 9'h100;
            play(vecs[i].ch, $sformatf("vec%0d", i));
            fi = -1;
            foreach (ev[k]) if (fi < 0 && ev[k].v && !ev[k].u) fi = k;
            chk($sformatf("vec%0d_found", i), 32'(fi >= 0), 32'h1);
            if (fi >= 0) begin
                chk($sformatf("vec%0d_tbl_left", i), 32'(ev[fi].l), 32'(vecs[i].el));
                chk($sformatf("vec%0d_tbl_right", i), 32'(ev[fi].r), 32'(vecs[i].er));
                chk($sformatf("vec%0d_tbl_eos", i), 32'(ev[fi].eos), 32'(vecs[i].eeos));
            end
        end

        // Starvation: every tick must produce a silent underrun strobe.
        w = 20000;
        do_reset("reset_ur");
        ev.delete();
        repeat (w) @(negedge clk);
        ur = 0; bad = 0;
        foreach (ev[k]) begin
            if (ev[k].u) ur++;
            if (!ev[k].u || !ev[k].v || ev[k].l != 0 || ev[k].r != 0) bad++;
        end
        chk("underrun_count", ur, 32'((longint'(w - 1) * SAMPLE_HZ) / CLK_HZ));
        chk("underrun_clean", bad, 0);

        // Stereo stream ending on byte 1 of frame 3.
        fill_random(0);
        mem[9][8] = 1'b1;
        play(2, "eos");
        chk("eos_frames", exp_q.size(), 3);
        chk("eos_last_right", 32'(exp_q[2].r), 32'h0);

        // Full drain and immediate refill resume from address 0.
        fill_random(0);
        play(1, "drain");
        chk("drain_frames", exp_q.size(), 8);
        fill_random(0);
        play(1, "refill");

        // Reset during playback drops the frame in flight.
        fill_random(0);
        ev.delete();
        wav_ch = 8'd2;
        @(negedge clk) buffer_filled_i = 1;
        @(negedge clk) buffer_filled_i = 0;
        fi = 0;
        while (fi < 200 && !(ev.size() > 0 && ev[ev.size() - 1].v && !ev[ev.size() - 1].u)) begin
            @(negedge clk);
            fi++;
        end
        chk("midreset_first_frame", 32'(fi < 200), 32'h1);
        repeat (21) @(negedge clk);
        do_reset("midreset");
        fill_random(0);
        play(2, "after_reset");

        for (int r = 0; r < 8; r++) begin
            idx = $urandom_range(4, 0);
            ch = (idx == 0) ? 0 : (idx == 1) ? 1 : (idx == 4) ? 3 : 2;
            fill_random($urandom_range(1, 0) == 1);
            play(ch, $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/audio_buffer_player.md
# audio_buffer_player

Consumer end of the audio buffer that the FAT32 reader fills. It waits for the writer's `filled` flag and then drains the buffer at the WAV sampling rate. Buffer bytes are assembled into 16-bit signed little-endian PCM frames (mono or stereo) and presented to the DAC/PWM stage with a per-sample strobe. When the buffer is drained or an end-of-stream marker is read, it hands the buffer back through `empty`.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency; must be ≥ 16×`SAMPLE_HZ`.
- `SAMPLE_HZ`, default 44100: output frame rate.
- `BUFFER_ADDR_BITS`, default from the buffer constants: buffer depth is 2^`BUFFER_ADDR_BITS` bytes, minimum 4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `buffer_addr_o`  out  `BUFFER_ADDR_BITS`  read address into the audio buffer RAM.
- `buffer_data_i`  in  9  RAM read data, 1-cycle latency. Bit 8 is the end-of-stream marker; [7:0] is the byte.
- `buffer_filled_i`  in  1  writer reports that the buffer is full and ready.
- `buffer_empty_o`  out  1  player reports that the buffer has been consumed and is free to refill.
- `wav_info_audio_channels`  in  8  channel count from the WAV header.
- `left_o`  out  16  left sample, signed.
- `right_o`  out  16  right sample, signed.
- `sample_valid_o`  out  1  1-cycle strobe when `left_o`/`right_o` update.
- `underrun_o`  out  1  1-cycle strobe when a sample tick finds no buffer available.
- `end_of_stream_o`  out  1  1-cycle strobe when the marker byte has been played.

## Operation
- **Tick generator:** 32-bit accumulator.
  - Each cycle: `acc += SAMPLE_HZ`.
  - If `acc ≥ CLK_HZ`: `acc -= CLK_HZ` and `tick` pulses for one cycle.
  - Long-run rate is exact.
- **Frame size N:** 4 bytes if the latched channel count equals 2, otherwise 2 (1 and any invalid value are treated as mono).
- **Byte order:**
  - Mono: lo, hi. `left_o = right_o` = the sample.
  - Stereo: L lo, L hi, R lo, R hi.
- **States:**
  - **WAIT:** `buffer_empty_o = 1`, `buffer_addr_o = 0`.
    - `buffer_filled_i = 1` → PLAY. Clear `buffer_empty_o`, latch the channel count.
    - `tick` in WAIT: outputs cleared to 0, `sample_valid_o` and `underrun_o` pulse.
  - **PLAY:** idle until `tick` → FETCH.
  - **FETCH:** issue N consecutive addresses, one per cycle, and capture the returning bytes.
    - If a captured byte has bit 8 set, the remaining bytes of the frame are forced to 0. Set the eos flag.
  - **EMIT:** register the frame to the outputs and pulse `sample_valid_o`.
    - If eos is set: pulse `end_of_stream_o`, set `buffer_empty_o`, address back to 0, go to WAIT.
    - Else if the address wrapped past 2^`BUFFER_ADDR_BITS`−1: set `buffer_empty_o`, go to WAIT.
    - Else: go to PLAY.
- **Wrap:** the address increments modulo the depth. Frames never straddle the wrap because the depth is a power of 2 ≥ 4.
- **Writer contract:** the writer deasserts `buffer_filled_i` after seeing `buffer_empty_o = 0` and before the buffer drains. While `buffer_empty_o = 0` the player ignores the level of `buffer_filled_i`.
- **Simultaneous `tick` and `buffer_filled_i` in WAIT:** the underrun takes effect (silence, `underrun_o` pulse) and the state also moves to PLAY. The first real frame is emitted on the next tick.
- Ticks arriving during FETCH/EMIT cannot occur, given the `CLK_HZ` constraint; no queueing is required.

## Timing
- **Reset values:**
  - `buffer_empty_o = 1`.
  - `buffer_addr_o`, `left_o`, `right_o`, accumulator = 0.
  - All strobes = 0.
  - State = WAIT.
- **Reset mid-operation:** takes effect on the next edge. The frame in progress is dropped and outputs go to 0.
- **Latency:** `tick` in cycle t.
  - Address a in t+1 … a+N−1 in t+N.
  - Last byte captured in t+N+1.
  - `sample_valid_o` and new outputs in t+N+2: mono 4 cycles, stereo 6 cycles.
- **Hand-back:** `buffer_empty_o` rises in the same cycle as the final `sample_valid_o`. From `buffer_filled_i` high in WAIT to `buffer_empty_o` low is 1 cycle.
- **Outputs between strobes:** held stable.

## Structure
- **Shared package:** state enum, frame-size constants (2/4), EOS bit index (8).
- **Buffer width:** reuse the existing buffer constants for `BUFFER_ADDR_BITS`.
- **Sub-module:** `sample_tick_gen` holds the accumulator and tick output, parameterised by `CLK_HZ`/`SAMPLE_HZ`.

## Test plan
- **Reset:** assert `rst_n` = 0 for 2 cycles → `buffer_empty_o` = 1, outputs 0, no strobes.
- **Mono:** buffer preloaded with 0x34,0x12,0xCD,0xAB, channels = 1, `filled` pulse → first strobe `left_o = right_o` = 0x1234, 4 cycles after the tick; next strobe 0xABCD.
- **Stereo:** buffer preloaded with 0x01,0x00,0xFF,0xFF, channels = 2 → `left_o` = 0x0001, `right_o` = 0xFFFF, strobe 6 cycles after the tick.
- **Underrun and rate:** `buffer_filled_i` held low, run for 1 s simulated at `CLK_HZ` = 1 MHz, `SAMPLE_HZ` = 44100 → exactly 44100 `underrun_o` strobes, outputs 0.
- **End of stream:** EOS bit set on byte 1 of frame 3, stereo → that frame has R = 0, `end_of_stream_o` pulses, `buffer_empty_o` rises in the same cycle, address back to 0.
- **Full drain:** `BUFFER_ADDR_BITS` = 4, mono, no EOS → 8 frames, then `buffer_empty_o` = 1 and the address wraps to 0. Refill with `filled` → playback resumes from address 0 with no lost frame.
